sp_256k: RTL and testbench
==========================

SP_256K -- requirements
Module: sp_256k

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed at 16384 words x 16 bits.
REQ-002 The block SHALL have port CK, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port AD, input, 14 bits: word address (0..16383).
REQ-005 The block SHALL have port DI, input, 16 bits: write data.
REQ-006 The block SHALL have port MASKWE, input, 4 bits: per-nibble write enables (bit n covers DI/word bits [4n+3:4n]).
REQ-007 The block SHALL have port WE, input, 1 bit: 1 selects write, 0 selects read.
REQ-008 The block SHALL have port CS, input, 1 bit: access enable.
REQ-009 The block SHALL have port STDBY, input, 1 bit: standby (no access, contents and DO kept).
REQ-010 The block SHALL have port SLEEP, input, 1 bit: sleep (no access, DO forced to 0).
REQ-011 The block SHALL have port PWROFF_N, input, 1 bit: active-low power-off (no access, DO forced to 0).
REQ-012 The block SHALL have port DO, output, 16 bits: registered read data.

Function
REQ-013 The block SHALL enable an access at a CK edge only when RST=0, PWROFF_N=1, SLEEP=0, STDBY=0 and CS=1.
REQ-014 On an enabled edge with WE=1, the block SHALL update each nibble n of word AD whose MASKWE[n]=1 with DI[4n+3:4n], and SHALL leave the other nibbles unchanged.
REQ-015 On an enabled write edge, DO SHALL hold its previous value; MASKWE=4'b0000 SHALL write nothing.
REQ-016 On an enabled edge with WE=0, DO SHALL load the full 16-bit word at AD, visible after that edge (read latency 1 cycle).
REQ-017 MASKWE SHALL be ignored on reads.
REQ-018 On an edge where CS=0, with RST=0, PWROFF_N=1, SLEEP=0 and STDBY=0, the block SHALL leave both memory and DO unchanged.
REQ-019 On an edge where STDBY=1, with RST=0, PWROFF_N=1 and SLEEP=0, the block SHALL leave both memory and DO unchanged, regardless of CS and WE.
REQ-020 On an edge where SLEEP=1 or PWROFF_N=0, the block SHALL clear DO to 16'h0000, block all writes, and retain memory contents.
REQ-021 The block SHALL apply control priority, highest first: RST, PWROFF_N=0, SLEEP=1, STDBY=1, CS=0, normal access.
REQ-022 The block SHALL initialise all 16384 memory words to 16'h0000 at time zero, and DO SHALL be 16'h0000 at time zero.
REQ-023 The block SHALL keep back-to-back accesses independent; a read immediately after a write to the same address SHALL return the newly written data.
REQ-024 The block SHALL need no wrap-around handling; all 14-bit AD values are valid words.

Reset
REQ-025 An edge with RST=1 SHALL clear DO to 16'h0000, SHALL NOT modify memory contents, and SHALL block any write on that edge.
REQ-026 After RST falls, the block SHALL behave normally starting with the next edge.

Verification
REQ-027 The bench SHALL check the full write/read path: write 16'hA5C3 to AD=0 and 16'h1234 to AD=16383 with MASKWE=4'hF, then read each -> DO=16'hA5C3 and 16'h1234 one cycle after their reads.
REQ-028 The bench SHALL check nibble masking, covering the byte-lane pattern: write 16'hFFFF to AD=5, then write 16'h0000 with MASKWE=4'b0011 -> read gives 16'hFF00; then write 16'h1234 with MASKWE=4'b1100 -> read gives 16'h1200.
REQ-029 The bench SHALL check deselect and standby: with DO=16'hA5C3, hold CS=0 with WE=1 to AD=0, then STDBY=1 with CS=1, WE=1 -> DO stays 16'hA5C3 and a later read of AD=0 returns 16'hA5C3.
REQ-030 The bench SHALL check sleep and power-off: with DO nonzero, assert SLEEP=1 for one edge -> DO=16'h0000; release, read AD=16383 -> 16'h1234; repeat with PWROFF_N=0 -> same results.
REQ-031 The bench SHALL check reset mid-operation: with DO=16'h1234, assert RST=1 on an edge with CS=1, WE=1, DI=16'hBEEF, AD=7 -> DO=16'h0000; a later read of AD=7 returns its prior value (16'h0000).
REQ-032 The bench SHALL check read-after-write and hold: write AD=9 then read AD=9 on the next edge -> new data appears; an idle edge (CS=0) afterwards keeps DO unchanged.

Source files
------------

// File: rtl/sp_256k.sv
// Single-port 16384 x 16 synchronous SRAM with nibble write masks and low-power controls.
// Latency: a read presents data on DO one CK edge after the read edge; writes land on the edge.
// No backpressure: an access is taken on every enabled edge; RST/PWROFF_N/SLEEP/STDBY/CS gate it.
//
// Ports:
//   CK       in   1  clock, all state changes on rising edge
//   RST      in   1  synchronous active-high reset (clears DO, memory untouched)
//   AD       in  14  word address
//   DI       in  16  write data
//   MASKWE   in   4  per-nibble write enables, bit n covers bits [4n+3:4n]
//   WE       in   1  1 = write, 0 = read
//   CS       in   1  access enable
//   STDBY    in   1  standby: no access, memory and DO held
//   SLEEP    in   1  sleep: no access, DO cleared, memory retained
//   PWROFF_N in   1  active-low power-off: no access, DO cleared, memory retained
//   DO       out 16  registered read data

module sp_256k (
  input  logic        CK,
  input  logic        RST,
  input  logic [13:0] AD,
  input  logic [15:0] DI,
  input  logic [3:0]  MASKWE,
  input  logic        WE,
  input  logic        CS,
  input  logic        STDBY,
  input  logic        SLEEP,
  input  logic        PWROFF_N,
  output logic [15:0] DO
);

  // Array and output register both start cleared at time zero; RST only
  // touches the output register, so the array needs its own initial value.
  logic [15:0] mem [16384] = '{default: 16'h0000};
  logic [15:0] do_q = 16'h0000;

  // Low-power states override everything below reset; they also force DO low.
  logic pwr_clr;
  logic acc_en;
  logic wr_en;
  logic rd_en;

  assign pwr_clr = !PWROFF_N || SLEEP;
  assign acc_en  = !RST && !pwr_clr && !STDBY && CS;
  assign wr_en   = acc_en && WE;
  assign rd_en   = acc_en && !WE;

  // Memory array: no reset so it maps onto a plain RAM macro.
  always_ff @(posedge CK) begin
    if (wr_en) begin
      for (int n = 0; n < 4; n++) begin
        if (MASKWE[n]) begin
          mem[AD][4*n +: 4] <= DI[4*n +: 4];
        end
      end
    end
  end

  // Output register: cleared by reset or low-power, loaded only on reads,
  // held on writes, deselect and standby.
  always_ff @(posedge CK) begin
    if (RST || pwr_clr) begin
      do_q <= 16'h0000;
    end else if (rd_en) begin
      do_q <= mem[AD];
    end
  end

  assign DO = do_q;

endmodule

// File: tb/tb_sp_256k.sv
// Self-checking bench for sp_256k: directed scenarios plus randomized traffic
// against an array-based reference model of the memory and output register.
// Sampling happens 1 time unit after each rising CK edge; inputs change on falling edges.

module tb_sp_256k;

  logic        CK;
  logic        RST;
  logic [13:0] AD;
  logic [15:0] DI;
  logic [3:0]  MASKWE;
  logic        WE;
  logic        CS;
  logic        STDBY;
  logic        SLEEP;
  logic        PWROFF_N;
  logic [15:0] DO;

  int n_cmp;
  int n_bad;

  // Reference model state
  logic [15:0] m_mem [16384];
  logic [15:0] m_do;

  sp_256k dut (
    .CK       (CK),
    .RST      (RST),
    .AD       (AD),
    .DI       (DI),
    .MASKWE   (MASKWE),
    .WE       (WE),
    .CS       (CS),
    .STDBY    (STDBY),
    .SLEEP    (SLEEP),
    .PWROFF_N (PWROFF_N),
    .DO       (DO)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: DO=%h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model of one clock edge, evaluated from the control priority list.
  task automatic model_edge();
    logic [15:0] bits;
    if (RST) begin
      m_do = 16'h0000;
    end else if (!PWROFF_N || SLEEP) begin
      m_do = 16'h0000;
    end else if (STDBY || !CS) begin
      // nothing changes
    end else if (WE) begin
      bits = {{4{MASKWE[3]}}, {4{MASKWE[2]}}, {4{MASKWE[1]}}, {4{MASKWE[0]}}};
      m_mem[AD] = (m_mem[AD] & ~bits) | (DI & bits);
    end else begin
      m_do = m_mem[AD];
    end
  endtask

  // One full cycle: drive on the falling edge, model the rising edge, check after it.
  task automatic cyc(input logic rst, input logic pwroff_n, input logic sleep,
                     input logic stdby, input logic cs, input logic we,
                     input logic [13:0] ad, input logic [15:0] di, input logic [3:0] mask);
    @(negedge CK);
    RST = rst; PWROFF_N = pwroff_n; SLEEP = sleep; STDBY = stdby;
    CS = cs; WE = we; AD = ad; DI = di; MASKWE = mask;
    @(posedge CK);
    model_edge();
    #1;
    chk("model", DO, m_do);
  endtask

  task automatic wr(input logic [13:0] ad, input logic [15:0] di, input logic [3:0] mask);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ad, di, mask);
  endtask

  task automatic rd(input logic [13:0] ad);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ad, 16'h0000, 4'h0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 16'h0000, 4'h0);
  endtask

  initial begin
    logic        r_rst, r_pwr, r_slp, r_stb, r_cs, r_we;
    logic [13:0] r_ad;
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 16384; i++) m_mem[i] = 16'h0000;
    m_do = 16'h0000;

    RST = 1'b0; PWROFF_N = 1'b1; SLEEP = 1'b0; STDBY = 1'b0;
    CS = 1'b0; WE = 1'b0; AD = '0; DI = '0; MASKWE = '0;

    // Time-zero state
    #1;
    chk("do_t0", DO, 16'h0000);

    // Reset edge, then a read of never-written memory
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 14'd0, 16'h0000, 4'h0);
    chk("do_rst", DO, 16'h0000);
    rd(14'd100);
    chk("init_zero", DO, 16'h0000);

    // Full write/read path at both ends of the address range
    wr(14'd0, 16'hA5C3, 4'hF);
    wr(14'd16383, 16'h1234, 4'hF);
    chk("wr_holds_do", DO, 16'h0000);
    rd(14'd0);
    chk("rd_ad0", DO, 16'hA5C3);
    rd(14'd16383);
    chk("rd_admax", DO, 16'h1234);

    // Nibble masking
    wr(14'd5, 16'hFFFF, 4'hF);
    wr(14'd5, 16'h0000, 4'b0011);
    rd(14'd5);
    chk("mask_lo", DO, 16'hFF00);
    wr(14'd5, 16'h1234, 4'b1100);
    chk("wr_keeps_do", DO, 16'hFF00);
    rd(14'd5);
    chk("mask_hi", DO, 16'h1200);

    // Deselect and standby
    rd(14'd0);
    chk("pre_desel", DO, 16'hA5C3);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 14'd0, 16'h0000, 4'hF);
    chk("desel_hold", DO, 16'hA5C3);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 14'd0, 16'h0000, 4'hF);
    chk("stdby_hold", DO, 16'hA5C3);
    rd(14'd0);
    chk("stdby_mem", DO, 16'hA5C3);

    // Sleep, then power-off, each with a write attempt that must be blocked
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 14'd16383, 16'hDEAD, 4'hF);
    chk("sleep_clr", DO, 16'h0000);
    rd(14'd16383);
    chk("sleep_mem", DO, 16'h1234);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 14'd16383, 16'hBEEF, 4'hF);
    chk("pwroff_clr", DO, 16'h0000);
    rd(14'd16383);
    chk("pwroff_mem", DO, 16'h1234);

    // Reset mid-operation blocks the write; normal operation on the very next edge
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 14'd7, 16'hBEEF, 4'hF);
    chk("rst_mid", DO, 16'h0000);
    rd(14'd7);
    chk("rst_nowr", DO, 16'h0000);

    // Read-after-write, idle hold, empty mask
    wr(14'd9, 16'hA9A9, 4'hF);
    rd(14'd9);
    chk("raw", DO, 16'hA9A9);
    idle();
    chk("idle_hold", DO, 16'hA9A9);
    wr(14'd9, 16'h0000, 4'h0);
    rd(14'd9);
    chk("mask_none", DO, 16'hA9A9);

    // Randomized traffic over a small hot address set plus the full range
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 31) == 0);
      r_pwr = ($urandom_range(0, 15) != 0);
      r_slp = ($urandom_range(0, 15) == 0);
      r_stb = ($urandom_range(0, 7) == 0);
      r_cs  = ($urandom_range(0, 3) != 0);
      r_we  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) r_ad = 14'($urandom_range(0, 16383));
      else                           r_ad = 14'($urandom_range(0, 15));
      cyc(r_rst, r_pwr, r_slp, r_stb, r_cs, r_we, r_ad,
          16'($urandom), 4'($urandom));
    end

    // Sweep-read the hot set so every written word is compared directly
    for (int a = 0; a < 16; a++) begin
      rd(14'(a));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
